// File: rtl/video_timing_pkg.sv
// Shared constants for the composite video timing stage and the text dot generator.
package video_timing_pkg;

  localparam int H_START        = 512;
  localparam int V_START        = 32;
  localparam int H_TOTAL        = 2032;
  localparam int V_TOTAL        = 262;
  localparam int COLS           = 40;
  localparam int ROWS           = 25;
  localparam int CLOCKS_PER_DOT = 4;
  localparam int FONT_W         = 8;
  localparam int FONT_H         = 8;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic {CLEAR, RUN} state_t;

endpackage

// File: rtl/text_dot_generator_char_rom.sv
// 1024x8 character ROM, address {glyph[6:0], row[2:0]}, one-cycle synchronous read.
module char_rom
  import video_timing_pkg::*;
(
  input  logic              clock,
  input  logic [9:0]        addr,
  output logic [FONT_W-1:0] data
);

  // Row 0 is the top byte; bit 7 of each row is the leftmost dot.
  function automatic logic [7:0] glyph_row(input logic [6:0] g, input logic [2:0] r);
    logic [63:0] bits;
    case (g)
      7'h20:   bits = 64'h0000000000000000;
      7'h41:   bits = 64'h183C66667E666600;
      7'h42:   bits = 64'h7C66667C66667C00;
      7'h48:   bits = 64'h6666667E66666600;
      default: bits = {8{1'b0, g}} ^ 64'h0102040810204080;
    endcase
    return bits[{~r, 3'b111} -: 8];
  endfunction

  always_ff @(posedge clock) begin
    data <= glyph_row(addr[9:3], addr[2:0]);
  end

endmodule

// File: rtl/text_dot_generator.sv
// 40x25 text-mode dot source aligned to the timing stage counters with zero visible latency.
module text_dot_generator
  import video_timing_pkg::*;
#(
  parameter int H_START        = video_timing_pkg::H_START,
  parameter int V_START        = video_timing_pkg::V_START,
  parameter int COLS           = video_timing_pkg::COLS,
  parameter int ROWS           = video_timing_pkg::ROWS,
  parameter int CLOCKS_PER_DOT = video_timing_pkg::CLOCKS_PER_DOT,
  parameter logic [7:0] FILL_CHAR = video_timing_pkg::FILL_CHAR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] clock_counter,
  input  logic [8:0]  line_counter,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        init_done,
  output logic        dot
);

  localparam int CELL  = FONT_W * CLOCKS_PER_DOT;
  localparam int CELLS = COLS * ROWS;
  localparam logic [9:0] CELLS_A = 10'(CELLS);
  localparam logic [9:0] LAST_A  = 10'(CELLS - 1);
  localparam logic signed [13:0] F0_OFF_S   = 14'(H_START - 4);
  localparam logic signed [13:0] LD_OFF_S   = 14'(H_START - 1);
  localparam logic signed [13:0] V_START_S  = 14'(V_START);
  localparam logic signed [13:0] CELL_S     = 14'(CELL);
  localparam logic signed [13:0] CPD_S      = 14'(CLOCKS_PER_DOT);
  localparam logic signed [13:0] ROW_CLKS_S = 14'(CELL * COLS);
  localparam logic signed [13:0] LINES_S    = 14'(FONT_H * ROWS);
  localparam logic signed [13:0] COLS_S     = 14'(COLS);
  localparam logic signed [13:0] FH_S       = 14'(FONT_H);

  state_t state, state_next;
  logic [9:0] clr_addr;

  logic signed [13:0] cc_s, y_s, rel_f0, rel_ld, cell_idx;
  logic line_act, ld_en, shift_en;

  logic       f0_p0;
  logic [9:0] rd_addr_p0, ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram [CELLS];

  logic [7:0] code_p1;
  logic       vld_p1;
  logic [7:0] glyph_p2;
  logic       inv_p2, vld_p2;
  logic [7:0] pend_p3;
  logic       inv_p3, vld_p3;
  logic [7:0] shift_p4;

  // Position decode: every decision is a comparison against the input counters.
  assign cc_s     = signed'({3'b000, clock_counter});
  assign y_s      = signed'({5'b00000, line_counter}) - V_START_S;
  assign rel_f0   = cc_s - F0_OFF_S;
  assign rel_ld   = cc_s - LD_OFF_S;
  assign cell_idx = (y_s / FH_S) * COLS_S + rel_f0 / CELL_S;
  assign line_act = (y_s >= 14'sd0) && (y_s < LINES_S);
  assign ld_en    = (rel_ld >= 14'sd0) && (rel_ld <= ROW_CLKS_S) && ((rel_ld % CELL_S) == 14'sd0);
  assign shift_en = (rel_ld % CPD_S) == 14'sd0;

  always_comb begin
    f0_p0      = (state == RUN) && line_act && (rel_f0 >= 14'sd0) && (rel_f0 < ROW_CLKS_S)
                 && ((rel_f0 % CELL_S) == 14'sd0);
    rd_addr_p0 = 10'(cell_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset)                clr_addr <= '0;
    else if (state == CLEAR)  clr_addr <= clr_addr + 10'd1;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_addr == LAST_A) state_next = RUN;
  end

  always_comb begin
    init_done = (state == RUN);
    wr_ready  = (state == RUN) && !f0_p0;
  end

  // Single text RAM port: fetch read beats clear and CPU writes.
  always_comb begin
    ram_addr  = wr_addr;
    ram_wdata = wr_data;
    ram_we    = wr_valid && wr_ready && (wr_addr < CELLS_A);
    if (state == CLEAR) begin
      ram_addr  = clr_addr;
      ram_wdata = FILL_CHAR;
      ram_we    = 1'b1;
    end
    if (f0_p0) begin
      ram_addr = rd_addr_p0;
      ram_we   = 1'b0;
    end
  end

  // F0 -> F1: text RAM read.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    code_p1 <= ram[ram_addr];
  end

  // F1 -> F2: glyph row lookup.
  char_rom u_char_rom (
    .clock (clock),
    .addr  ({code_p1[6:0], y_s[2:0]}),
    .data  (glyph_p2)
  );

  // F2 -> F3: pending row waits for the cell boundary.
  always_ff @(posedge clock) begin
    inv_p2  <= code_p1[7];
    pend_p3 <= glyph_p2;
    inv_p3  <= inv_p2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= f0_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // F3 -> dot: load at the cell boundary, shift once per dot period.
  always_ff @(posedge clock) begin
    if (reset)         shift_p4 <= '0;
    else if (ld_en)    shift_p4 <= vld_p3 ? (pend_p3 ^ {8{inv_p3}}) : 8'h00;
    else if (shift_en) shift_p4 <= {shift_p4[6:0], 1'b0};
  end

  assign dot = shift_p4[7];

endmodule

// File: doc/text_dot_generator.md
Name: text_dot_generator

Overview:
- Text-mode pixel source feeding the luminance input of the composite video timing stage (2032 clocks/line, 262 lines/frame).
- Takes that stage's clock_counter/line_counter and produces the dot for each position of a 40x25-character, 8x8-font screen (320x200 dots, 4 clocks per dot).
- Holds a 1000-byte text RAM with a valid/ready write port for the CPU side, and an 8x8 character ROM.

Parameters:
- H_START, 512, first clock_counter value of the active area
- V_START, 32, first line_counter value of the active area
- COLS, 40, characters per row
- ROWS, 25, character rows
- CLOCKS_PER_DOT, 4, clocks per dot; one cell is 8*CLOCKS_PER_DOT clocks; minimum 1
- FILL_CHAR, 8'h20, code written to every text RAM cell during clear

Ports:
- clock  in  1  system clock, same clock as the timing stage
- reset  in  1  synchronous, active-high
- clock_counter  in  11  horizontal position from the timing stage, 0..2031
- line_counter  in  9  line number from the timing stage, 0..261
- wr_valid  in  1  CPU write request
- wr_ready  out  1  write accepted on a cycle with wr_valid & wr_ready
- wr_addr  in  10  text RAM address, row*COLS+col
- wr_data  in  8  bits 6:0 are the glyph; bit 7 selects inverse video
- init_done  out  1  high once the clear sequence has finished
- dot  out  1  luminance for the current (clock_counter, line_counter)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clock, reset port is reset.
- Reset values: dot=0, wr_ready=0, init_done=0; FSM enters CLEAR with the clear address at 0.
- CLEAR: writes FILL_CHAR to address a each cycle for a=0..COLS*ROWS-1 (1000 cycles), then goes to RUN and sets init_done=1. dot=0 throughout CLEAR.
- Reset asserted in any state, including mid-clear or mid-line: returns to the reset values and restarts CLEAR from address 0.
- Active area: x=clock_counter-H_START in 0..8*COLS*CLOCKS_PER_DOT-1 and y=line_counter-V_START in 0..8*ROWS-1.
  - Outside the active area, dot=0.
  - Inside it, dot = font[code[6:0]][y mod 8][7 - (x/CLOCKS_PER_DOT mod 8)] XOR code[7], where code = RAM[(y/8)*COLS + x/(8*CLOCKS_PER_DOT)]. Bit 7 of the font row is the leftmost dot.
- Alignment: dot is driven from registers only. During the cycle in which the inputs show (c,l), dot already equals the value for (c,l); there is zero latency visible to the timing stage.
- Fetch pipeline, per cell k on active lines:
  - F0 at clock_counter = H_START + 32k - 4 (32 = 8*CLOCKS_PER_DOT): text RAM read.
  - F1: char_rom address = {code[6:0], y[2:0]}; code[7] held alongside.
  - F2: ROM data captured into a pending register.
  - At the edge where clock_counter = H_START + 32k - 1, the pending register loads the 8-bit shift register.
  - The shift register shifts left once every CLOCKS_PER_DOT clocks.
- The active flag is registered in the same way, so the first dot appears at H_START and the area ends at H_START+1280 (=1792).
- Write port:
  - wr_ready=1 in RUN except in F0 cycles on active lines, since the text RAM is single-ported and the read wins.
  - Accept means the write takes effect at the next edge.
  - wr_addr >= COLS*ROWS is accepted and discarded.
  - A write to a cell after its F0 for the current line shows from the next line's fetch onward.
  - wr_valid in CLEAR is ignored (wr_ready=0).
- Simultaneous F0 and wr_valid: the read proceeds and the write stalls exactly one cycle.
- Counter wrap (2031->0, 261->0) needs no special handling; all decisions are comparisons on the input counters.

Decomposition:
- Package video_timing_pkg: H_START, V_START, H_TOTAL=2032, V_TOTAL=262, COLS, ROWS, CLOCKS_PER_DOT, FONT_W=8, FONT_H=8, FILL_CHAR, and the FSM state enum {CLEAR, RUN}. The timing stage imports the same constants.
- One sub-module, char_rom: 1024x8 ROM with synchronous read, address {glyph[6:0], row[2:0]}; glyph 0x20 is all zeros.

Test Plan:
- Clear: pulse reset for 1 cycle -> init_done rises exactly 1000 cycles later; a whole frame afterwards gives dot=0 everywhere (space glyph).
- Glyph: write 0x41 to address 0 -> on line 32, dot at clocks 512..543 follows font[0x41][0] MSB first, each bit held 4 clocks; dot=0 at clock 511 and 544 onward if cell 1 is a space.
- Inverse and corner: write 0xC1 to address 999 -> on lines 224..231, clocks 1760..1791 show ~font[0x41][y mod 8]; dot=0 at clock 1792 and on line 232.
- Write stall: hold wr_valid at clock_counter=508 on line 40 -> wr_ready=0 that cycle, write accepted at 509; write to address 1000 is accepted and RAM is unchanged.
- Mid-frame reset: with all cells = 0xA0 (inverse space, full white), assert reset at line 100, clock 900 -> dot=0 from the next cycle; init_done=0 for 1000 cycles; white returns after the clear only if the cells are rewritten.
- Area edges: all cells 0xA0 -> dot=1 exactly for clocks 512..1791 on lines 32..231; dot=0 at clocks 511 and 1792 and on lines 31 and 232.
